// File: rtl/router_pkg.sv
// Shared router types and default sizing for the VC input buffer slice.
package router_pkg;
  localparam int ROUTER_FLITW    = 32;
  localparam int ROUTER_NUM_VCS  = 4;
  localparam int ROUTER_VC_DEPTH = 4;
  localparam int ROUTER_VCIDW    = $clog2(ROUTER_NUM_VCS);

  typedef logic [ROUTER_VCIDW-1:0] vc_id_t;
  typedef logic [ROUTER_FLITW-1:0] flit_t;
endpackage

// File: rtl/vc_fifo.sv
// Single-VC circular FIFO. Head entry, occupancy and non-empty flag are all
// registered. Pointers wrap explicitly so DEPTH need not be a power of two.
module vc_fifo
  import router_pkg::*;
#(
  parameter  int FLITW = ROUTER_FLITW,
  parameter  int DEPTH = ROUTER_VC_DEPTH,
  localparam int CNTW  = $clog2(DEPTH + 1),
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [FLITW-1:0] push_data,
  input  logic             pop,
  output logic [FLITW-1:0] head,
  output logic             head_valid,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             popped
);
  logic [FLITW-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  // Full is judged on the pre-edge count: a pop in the same cycle does not
  // make room for the incoming flit.
  always_comb begin
    do_push  = push && (count_q != CNTW'(DEPTH));
    do_pop   = pop && valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = valid_q;
  assign count      = count_q;
  assign full       = (count_q == CNTW'(DEPTH));
  assign popped     = do_pop;
endmodule

// File: rtl/vc_input_buffer.sv
// Per-port input buffer: steers link flits into per-VC FIFOs, exposes each
// VC head, returns one credit per dequeued flit and flags dropped flits.
module vc_input_buffer
  import router_pkg::*;
#(
  parameter  int FLITW    = ROUTER_FLITW,
  parameter  int NUM_VCS  = ROUTER_NUM_VCS,
  parameter  int VC_DEPTH = ROUTER_VC_DEPTH,
  localparam int VCIDW    = $clog2(NUM_VCS),
  localparam int CNTW     = $clog2(VC_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [FLITW-1:0]   in_flit,
  input  logic [VCIDW-1:0]   in_vc,
  input  logic [NUM_VCS-1:0] deq,
  output logic [NUM_VCS-1:0] head_valid,
  output logic [FLITW-1:0]   head_flit [NUM_VCS],
  output logic [CNTW-1:0]    vc_count [NUM_VCS],
  output logic [NUM_VCS-1:0] credit_out,
  output logic               overflow_err
);
  logic [NUM_VCS-1:0] push, full, popped;
  logic [NUM_VCS-1:0] credit_q, credit_d;
  logic               ovf_q, ovf_d;
  logic               vc_ok;

  // Out-of-range VC ids (possible when NUM_VCS is not a power of two) are
  // treated like a full VC: dropped and flagged.
  always_comb begin
    vc_ok = (int'(in_vc) < NUM_VCS);
    push  = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (in_valid && vc_ok && (int'(in_vc) == v)) push[v] = 1'b1;
    end
    ovf_d = ovf_q;
    if (in_valid && (!vc_ok || |(push & full))) ovf_d = 1'b1;
    credit_d = popped;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    vc_fifo #(
      .FLITW (FLITW),
      .DEPTH (VC_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push[v]),
      .push_data  (in_flit),
      .pop        (deq[v]),
      .head       (head_flit[v]),
      .head_valid (head_valid[v]),
      .count      (vc_count[v]),
      .full       (full[v]),
      .popped     (popped[v])
    );
  end

  assign credit_out   = credit_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: a 4x4 build and a 3-VC/3-deep build share one
// stimulus stream and are both checked each cycle against a queue model.
module tb_vc_input_buffer;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_flit;
  logic [1:0]  in_vc;
  logic [3:0]  deq;

  logic [3:0]  hv0, cr0;
  logic [31:0] hf0 [4];
  logic [2:0]  cnt0 [4];
  logic        ov0;
  logic [2:0]  hv3, cr3;
  logic [31:0] hf3 [3];
  logic [1:0]  cnt3 [3];
  logic        ov3;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  vc_input_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit), .in_vc(in_vc),
    .deq(deq), .head_valid(hv0), .head_flit(hf0), .vc_count(cnt0),
    .credit_out(cr0), .overflow_err(ov0)
  );

  vc_input_buffer #(.NUM_VCS(3), .VC_DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit), .in_vc(in_vc),
    .deq(deq[2:0]), .head_valid(hv3), .head_flit(hf3), .vc_count(cnt3),
    .credit_out(cr3), .overflow_err(ov3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Uniform view of both DUTs
  logic [3:0]  a_hv [2];
  logic [3:0]  a_cr [2];
  logic        a_ov [2];
  logic [31:0] a_hf [2][4];
  logic [31:0] a_cnt [2][4];
  always_comb begin
    a_hv[0] = hv0;  a_hv[1] = {1'b0, hv3};
    a_cr[0] = cr0;  a_cr[1] = {1'b0, cr3};
    a_ov[0] = ov0;  a_ov[1] = ov3;
    for (int v = 0; v < 4; v++) begin
      a_hf[0][v]  = hf0[v];
      a_cnt[0][v] = 32'(cnt0[v]);
      a_hf[1][v]  = '0;
      a_cnt[1][v] = '0;
    end
    for (int v = 0; v < 3; v++) begin
      a_hf[1][v]  = hf3[v];
      a_cnt[1][v] = 32'(cnt3[v]);
    end
  end

  // Behavioural model: one queue per VC per build
  logic [31:0] mq [2][4][$];
  logic [3:0]  mcred [2];
  logic        movf [2];
  int          pre [4];
  int          nv, dp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int v = 0; v < 4; v++) mq[d][v].delete();
        mcred[d] = '0;
        movf[d]  = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        nv = (d == 0) ? 4 : 3;
        dp = (d == 0) ? 4 : 3;
        for (int v = 0; v < 4; v++) pre[v] = mq[d][v].size();
        mcred[d] = '0;
        if (in_valid && (int'(in_vc) >= nv || pre[in_vc] >= dp)) movf[d] = 1'b1;
        for (int v = 0; v < nv; v++) begin
          if (deq[v] && pre[v] > 0) begin
            void'(mq[d][v].pop_front());
            mcred[d][v] = 1'b1;
          end
        end
        if (in_valid && int'(in_vc) < nv && pre[in_vc] < dp) mq[d][in_vc].push_back(in_flit);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int v = 0; v < ((d == 0) ? 4 : 3); v++) begin
          chk($sformatf("m_hv d%0d v%0d", d, v), 32'(a_hv[d][v]), 32'(mq[d][v].size() > 0));
          chk($sformatf("m_cnt d%0d v%0d", d, v), a_cnt[d][v], 32'(mq[d][v].size()));
          if (mq[d][v].size() > 0)
            chk($sformatf("m_hf d%0d v%0d", d, v), a_hf[d][v], mq[d][v][0]);
        end
        chk($sformatf("m_cr d%0d", d), 32'(a_cr[d]), 32'(mcred[d]));
        chk($sformatf("m_ov d%0d", d), 32'(a_ov[d]), 32'(movf[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_flit = '0; in_vc = '0; deq = '0;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_hv", 32'(hv0), 32'h0);
    chk("rst_cr", 32'(cr0), 32'h0);
    chk("rst_ov", 32'(ov0), 32'h0);
    for (int v = 0; v < 4; v++) chk($sformatf("rst_cnt%0d", v), 32'(cnt0[v]), 32'h0);
    reset = 1'b1;
    tick();

    // Two flits to VC2, one dequeue
    in_valid = 1'b1; in_vc = 2'd2; in_flit = 32'hA1;
    tick();
    chk("a1_hv", 32'(hv0), 32'h4);
    chk("a1_hf", hf0[2], 32'hA1);
    in_flit = 32'hA2;
    tick();
    in_valid = 1'b0;
    chk("a2_cnt", 32'(cnt0[2]), 32'd2);
    deq = 4'b0100;
    tick();
    deq = '0;
    chk("a_deq_hf", hf0[2], 32'hA2);
    chk("a_deq_cr", 32'(cr0), 32'h4);
    tick();
    chk("a_cr_once", 32'(cr0), 32'h0);
    deq = 4'b0100;
    tick();
    deq = '0;

    // Fill VC0 past capacity, then drain
    in_valid = 1'b1; in_vc = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_flit = 32'h10 + 32'(i);
      tick();
    end
    in_flit = 32'hFF;
    tick();
    in_valid = 1'b0;
    chk("full_cnt", 32'(cnt0[0]), 32'd4);
    chk("full_ov", 32'(ov0), 32'h1);
    deq = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_hf%0d", i), hf0[0], 32'h10 + 32'(i));
      tick();
      chk($sformatf("drain_cr%0d", i), 32'(cr0), 32'h1);
    end
    deq = '0;
    tick();
    chk("drain_cnt", 32'(cnt0[0]), 32'd0);
    chk("ov_sticky", 32'(ov0), 32'h1);
    chk("drain_cr_end", 32'(cr0), 32'h0);

    // Simultaneous enq+deq on non-empty VC1 and empty VC3
    rst_pulse();
    in_valid = 1'b1; in_vc = 2'd1; in_flit = 32'hB0;
    tick();
    in_flit = 32'hB1;
    tick();
    in_flit = 32'hB2; deq = 4'b0010;
    tick();
    chk("ed_cnt1", 32'(cnt0[1]), 32'd2);
    chk("ed_hf1", hf0[1], 32'hB1);
    in_vc = 2'd3; in_flit = 32'hC0; deq = 4'b1000;
    tick();
    in_valid = 1'b0; deq = '0;
    chk("ed_cnt3", 32'(cnt0[3]), 32'd1);
    chk("ed_cr3", 32'(cr0), 32'h0);
    chk("ed_hf3", hf0[3], 32'hC0);
    deq = 4'b1010;
    tick();
    chk("ed_hf1b", hf0[1], 32'hB2);
    chk("ed_cr_multi", 32'(cr0), 32'hA);
    deq = 4'b0010;
    tick();
    deq = '0;
    tick();

    // Pointer wrap: ten push/pop cycles on VC1
    rst_pulse();
    in_valid = 1'b1; in_vc = 2'd1; in_flit = 32'h100;
    tick();
    in_flit = 32'h101;
    tick();
    deq = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      in_flit = 32'h102 + 32'(i);
      tick();
      chk($sformatf("wrap_hf%0d", i), hf3[1], 32'h101 + 32'(i));
      chk($sformatf("wrap_cnt%0d", i), 32'(cnt3[1]), 32'd2);
    end
    in_valid = 1'b0;
    tick();
    tick();
    deq = '0;
    tick();

    // Out-of-range VC id on the 3-VC build
    in_valid = 1'b1; in_vc = 2'd3; in_flit = 32'h77;
    tick();
    in_valid = 1'b0;
    chk("badvc_ov3", 32'(ov3), 32'h1);
    chk("badvc_ov0", 32'(ov0), 32'h0);
    chk("badvc_cnt0", 32'(cnt0[3]), 32'd1);

    // Asynchronous reset mid-burst with a dequeue pending
    in_valid = 1'b1; in_vc = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_flit = 32'h30 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_cnt", 32'(cnt0[0]), 32'd3);
    deq = 4'b0001;
    #2 reset = 1'b0;
    #1;
    chk("mid_hv", 32'(hv0), 32'h0);
    chk("mid_cnt0", 32'(cnt0[0]), 32'd0);
    chk("mid_cr", 32'(cr0), 32'h0);
    chk("mid_ov", 32'(ov0), 32'h0);
    tick();
    chk("mid_cr_edge", 32'(cr0), 32'h0);
    #2 reset = 1'b1;
    deq = '0;
    in_valid = 1'b1; in_vc = 2'd0; in_flit = 32'h55;
    tick();
    in_valid = 1'b0;
    chk("post_hv", 32'(hv0), 32'h1);
    chk("post_hf", hf0[0], 32'h55);
    tick();
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
Per-port input buffer of the virtual channel router. It accepts flits from the link, steers each flit into the FIFO of its virtual channel, and presents every VC's head flit to the downstream pipe_register_2D-fed route-compute/VC-allocation stage as a per-VC unpacked array. Each flit dequeued by downstream returns one credit to the upstream router on a per-VC pulse vector.

Parameters:
FLITW, 32, flit width in bits
NUM_VCS, 4, number of virtual channels per input port (>=2)
VC_DEPTH, 4, flit slots per VC (>=2; need not be a power of two)
VCIDW, $clog2(NUM_VCS), VC id width (derived; not overridden)
CNTW, $clog2(VC_DEPTH+1), occupancy count width (derived)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset; state clears while reset==0
in_valid  input  1  flit present on link this cycle
in_flit  input  FLITW  incoming flit
in_vc  input  VCIDW  target VC of incoming flit
deq  input  NUM_VCS  downstream pops head of VC v (bit v)
head_valid  output  NUM_VCS  VC v holds at least one flit
head_flit  output  FLITW x [NUM_VCS] unpacked  head flit of each VC
vc_count  output  CNTW x [NUM_VCS] unpacked  occupancy of each VC
credit_out  output  NUM_VCS  one-cycle credit pulse per VC to upstream
overflow_err  output  1  sticky: a flit arrived for a full VC

Behaviour:
- Reset (reset==0, asynchronous): all counts, read/write pointers 0; head_valid=0, vc_count=0, credit_out=0, overflow_err=0. Storage array is not reset; head_flit is don't-care while head_valid=0. Reset mid-operation discards all buffered flits; no credits are emitted for them.
- Enqueue: in_valid=1 and VC in_vc not full (count<VC_DEPTH): flit written at wr_ptr, wr_ptr advances, count+1.
- Full: in_valid=1 to a full VC: flit dropped, no state change for that VC, overflow_err set to 1 and held until reset.
- Dequeue: deq[v]=1 and head_valid[v]=1: rd_ptr advances, count-1, credit_out[v]=1 in the following cycle. deq[v] with head_valid[v]=0 is ignored (no credit, no pointer move).
- Multiple VCs may dequeue in the same cycle; credit_out can have several bits set.
- Simultaneous enq+deq on same non-empty VC: both take effect, count unchanged. Same cycle on an empty VC: enqueue only (no bypass); deq ignored.
- Latency: flit accepted at edge N appears at head_flit/head_valid after edge N (visible in cycle N+1). head_valid[v] == (vc_count[v]!=0), both registered.
- Pointer wrap: pointer == VC_DEPTH-1 wraps to 0 explicitly (non-power-of-two safe).
- head_flit[v] = storage[v][rd_ptr[v]]; updates the cycle after a dequeue to the next entry.
- in_vc >= NUM_VCS (non-power-of-two NUM_VCS): flit dropped, overflow_err set.

Decomposition:
- Shared package (router_pkg): FLITW, NUM_VCS, VC_DEPTH defaults, vc_id_t typedef, flit_t typedef.
- One sub-module: vc_fifo (single-VC circular FIFO: push/pop, count, head, wrap logic), instantiated NUM_VCS times via generate; vc_input_buffer does in_vc decode, credit register, overflow flag.

Test Plan:
- Reset then idle -> head_valid=0000, vc_count all 0, credit_out=0000, overflow_err=0.
- Enqueue 0xA1,0xA2 to VC2 on consecutive cycles -> cycle after first: head_valid=0100, head_flit[2]=0xA1, vc_count[2]=2 after second; deq[2] once -> head_flit[2]=0xA2, credit_out=0100 for exactly one cycle.
- Fill VC0 with 4 flits, send 5th (0xFF) -> vc_count[0]=4, 0xFF dropped, overflow_err=1 and stays 1; drain 4 -> order 0x10..0x13, 4 credits on bit 0.
- VC1 with 2 flits, enq+deq same cycle -> vc_count[1] stays 2, FIFO order preserved; empty VC3 enq+deq same cycle -> deq ignored, vc_count[3]=1, no credit.
- 10 push/pop cycles on VC1 with VC_DEPTH=3 build -> pointers wrap, output order equals input order.
- Assert reset low mid-burst with VC0=3 flits -> outputs clear immediately (asynchronously), no credit_out pulse; after release, new flit 0x55 to VC0 appears as head.
